// File: rtl/io_pkg.sv
// Shared definitions for the board I/O conditioning slice.
//   NUM_BTN / SW_W : number of push-buttons and slide switches on the board.
//   btn_level_e    : logical button level, independent of board polarity.
//   board_level()  : maps a logical level onto the physical pin level.
package io_pkg;

  localparam int NUM_BTN = 4;
  localparam int SW_W    = 32;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_level_e;

  // With active-low buttons a press reads as 0 on the pin, so the logical
  // level is simply inverted.
  function automatic logic board_level(input btn_level_e lvl, input bit active_low);
    return (lvl == BTN_PRESSED) ^ active_low;
  endfunction

endpackage

// File: rtl/io_input_cond_debounce_bit.sv
// Single push-button conditioner: 2-flop synchroniser, debounce counter and
// press/release event pulses. All outputs keep board polarity.
//   i_clk, i_rst : core clock, synchronous active-high reset
//   i_raw        : asynchronous button pin
//   o_level      : debounced level (registered)
//   o_press      : one-cycle pulse when the debounced level becomes pressed
//   o_release    : one-cycle pulse when the debounced level becomes released
module debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 500000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int       CW      = $clog2(DB_CYCLES);
  localparam logic     REL_LVL = board_level(BTN_RELEASED, BTN_ACTIVE_LOW);
  localparam logic     PRS_LVL = board_level(BTN_PRESSED, BTN_ACTIVE_LOW);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          btn_s1;
  logic          btn_s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          press_q;
  logic          release_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_s1    <= REL_LVL;
      btn_s2    <= REL_LVL;
      stable    <= REL_LVL;
      cnt       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // synchroniser stage
      btn_s1    <= i_raw;
      btn_s2    <= btn_s1;
      // debounce stage: pulses default low so each lasts exactly one cycle
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (btn_s2 == stable) begin
        // any agreeing cycle restarts the qualification window
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= '0;
        if (~stable == PRS_LVL) press_q   <= 1'b1;
        else                    release_q <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign o_level   = stable;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: rtl/io_input_cond.sv
// Input conditioning for board switches and push-buttons, feeding the core's
// switch/button MMIO inputs. Outputs keep board polarity.
//   i_clk, i_rst  : core clock, synchronous active-high reset
//   i_sw_raw      : asynchronous slide switches
//   i_btn_raw     : asynchronous push-buttons (board polarity)
//   o_io_sw       : synchronised switches
//   o_io_btn      : debounced buttons (board polarity)
//   o_btn_press   : one-cycle pulse per button on a debounced press
//   o_btn_release : one-cycle pulse per button on a debounced release
module io_input_cond
  import io_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 500000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SW_W-1:0]    i_sw_raw,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [SW_W-1:0]    o_io_sw,
  output logic [NUM_BTN-1:0] o_io_btn,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_release
);

  logic [SW_W-1:0] sw_s1;
  logic [SW_W-1:0] sw_s2;

  // Switches are level inputs sampled by firmware, so they only need
  // metastability protection, not debouncing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= i_sw_raw;
      sw_s2 <= sw_s1;
    end
  end

  assign o_io_sw = sw_s2;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DB_CYCLES      (DB_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raw     (i_btn_raw[i]),
      .o_level   (o_io_btn[i]),
      .o_press   (o_btn_press[i]),
      .o_release (o_btn_release[i])
    );
  end

endmodule

// File: tb/tb_io_input_cond.sv
module tb_io_input_cond;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_press;
  logic [3:0]  btn_release;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  btn;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [31:0] sw;
    string       tag;
  } exp_t;

  exp_t sb[$];

  io_input_cond #(
    .DB_CYCLES      (4),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sw_raw      (sw_raw),
    .i_btn_raw     (btn_raw),
    .o_io_sw       (io_sw),
    .o_io_btn      (io_btn),
    .o_btn_press   (btn_press),
    .o_btn_release (btn_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the expected post-edge outputs, then pop and compare
  // once the edge has passed.
  task automatic cycle(input logic [3:0] b, input logic [31:0] s, input logic r,
                       input logic [3:0] eb, input logic [3:0] ep, input logic [3:0] er,
                       input logic [31:0] es, input string tag);
    exp_t e;
    btn_raw = b;
    sw_raw  = s;
    rst     = r;
    e.btn = eb; e.press = ep; e.rel = er; e.sw = es; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".btn"},     {28'd0, io_btn},      {28'd0, e.btn});
    check({e.tag, ".press"},   {28'd0, btn_press},   {28'd0, e.press});
    check({e.tag, ".release"}, {28'd0, btn_release}, {28'd0, e.rel});
    check({e.tag, ".sw"},      io_sw,                e.sw);
  endtask

  task automatic run(input int n, input logic [3:0] b, input logic [31:0] s, input logic r,
                     input logic [3:0] eb, input logic [31:0] es, input string tag);
    for (int k = 0; k < n; k++) cycle(b, s, r, eb, 4'h0, 4'h0, es, tag);
  endtask

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] PAT  = 32'hA5A5_5A5A;

  initial begin
    btn_raw = 4'h0;
    sw_raw  = ONES;
    rst     = 1'b1;

    // Reset values with all buttons pressed and all switches on
    run(3, 4'h0, ONES, 1'b1, 4'hF, 32'h0, "reset");
    run(1, 4'h0, ONES, 1'b0, 4'hF, 32'h0, "post_rst_e1");
    run(4, 4'h0, ONES, 1'b0, 4'hF, ONES, "post_rst_e2_5");
    cycle(4'h0, ONES, 1'b0, 4'h0, 4'hF, 4'h0, ONES, "post_rst_e6");
    run(2, 4'h0, ONES, 1'b0, 4'h0, ONES, "post_rst_after");

    // Release all, with a switch pattern change riding along
    run(1, 4'hF, PAT, 1'b0, 4'h0, ONES, "rel_all_e1");
    run(4, 4'hF, PAT, 1'b0, 4'h0, PAT, "rel_all_e2_5");
    cycle(4'hF, PAT, 1'b0, 4'hF, 4'h0, 4'hF, PAT, "rel_all_e6");
    run(2, 4'hF, PAT, 1'b0, 4'hF, PAT, "rel_all_after");

    // Clean press of button 2
    run(5, 4'b1011, PAT, 1'b0, 4'hF, PAT, "press2_wait");
    cycle(4'b1011, PAT, 1'b0, 4'b1011, 4'b0100, 4'h0, PAT, "press2_e6");
    run(3, 4'b1011, PAT, 1'b0, 4'b1011, PAT, "press2_after");

    // Bounce on button 0: 2-cycle runs never qualify
    run(2, 4'b1010, PAT, 1'b0, 4'b1011, PAT, "bounce_lo1");
    run(2, 4'b1011, PAT, 1'b0, 4'b1011, PAT, "bounce_hi1");
    run(2, 4'b1010, PAT, 1'b0, 4'b1011, PAT, "bounce_lo2");
    run(2, 4'b1011, PAT, 1'b0, 4'b1011, PAT, "bounce_hi2");
    run(5, 4'b1010, PAT, 1'b0, 4'b1011, PAT, "bounce_hold");
    cycle(4'b1010, PAT, 1'b0, 4'b1010, 4'b0001, 4'h0, PAT, "bounce_e6");
    run(2, 4'b1010, PAT, 1'b0, 4'b1010, PAT, "bounce_after");

    // Release buttons 0 and 2 together
    run(5, 4'hF, PAT, 1'b0, 4'b1010, PAT, "rel02_wait");
    cycle(4'hF, PAT, 1'b0, 4'hF, 4'h0, 4'b0101, PAT, "rel02_e6");
    run(2, 4'hF, PAT, 1'b0, 4'hF, PAT, "rel02_after");

    // Buttons 1 and 3 pressed together, then released together
    run(5, 4'b0101, PAT, 1'b0, 4'hF, PAT, "press13_wait");
    cycle(4'b0101, PAT, 1'b0, 4'b0101, 4'b1010, 4'h0, PAT, "press13_e6");
    run(3, 4'b0101, PAT, 1'b0, 4'b0101, PAT, "press13_after");
    run(5, 4'hF, PAT, 1'b0, 4'b0101, PAT, "rel13_wait");
    cycle(4'hF, PAT, 1'b0, 4'hF, 4'h0, 4'b1010, PAT, "rel13_e6");
    run(2, 4'hF, PAT, 1'b0, 4'hF, PAT, "rel13_after");

    // Reset in the middle of debouncing a press on button 1
    run(3, 4'b1101, PAT, 1'b0, 4'hF, PAT, "midrst_pre");
    run(1, 4'b1101, PAT, 1'b1, 4'hF, 32'h0, "midrst_rst");
    run(1, 4'b1101, PAT, 1'b0, 4'hF, 32'h0, "midrst_e1");
    run(4, 4'b1101, PAT, 1'b0, 4'hF, PAT, "midrst_e2_5");
    cycle(4'b1101, PAT, 1'b0, 4'b1101, 4'b0010, 4'h0, PAT, "midrst_e6");
    run(2, 4'b1101, PAT, 1'b0, 4'b1101, PAT, "midrst_after");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_input_cond.md
# io_input_cond

Input conditioning stage for the board switches and push-buttons, placed directly upstream of the `single_cycle` core's `i_io_sw` / `i_io_btn` inputs.
- Synchronises all 32 asynchronous switch lines into the core clock domain.
- Synchronises and debounces the 4 push-buttons, and emits one-cycle press/release event pulses.
- Outputs keep board polarity, so existing firmware reading the switch and button MMIO registers runs unchanged.

## Interface
- `DB_CYCLES`, default 500000: consecutive cycles a synchronised button level must differ from the debounced level before the debounced output flips. Legal range is ≥ 2.
- `BTN_ACTIVE_LOW`, default 1: when 1, a raw button level of 0 means pressed. This sets the released/reset level and the pulse polarity.
- `i_clk  in  1`: core clock. One clock only.
- `i_rst  in  1`: reset, synchronous and active-high.
- `i_sw_raw  in  32`: asynchronous slide switches.
- `i_btn_raw  in  4`: asynchronous push-buttons, board polarity.
- `o_io_sw  out  32`: synchronised switches. Connects to core `i_io_sw`.
- `o_io_btn  out  4`: debounced buttons, board polarity. Connects to core `i_io_btn`.
- `o_btn_press  out  4`: one-cycle pulse per bit when that debounced button becomes pressed.
- `o_btn_release  out  4`: one-cycle pulse per bit when that debounced button becomes released.

## Operation
- **Switches:** 2-flop synchroniser per bit (`sw_s1`, `sw_s2`); `o_io_sw = sw_s2`. No debounce.
- **Buttons:** per bit, a 2-flop synchroniser (`btn_s1`, `btn_s2`) feeds a debounce FSM. FSM state is the debounced level `stable` plus a counter `cnt` of width `$clog2(DB_CYCLES)`. Per cycle:
  - `btn_s2 == stable`: `cnt` is cleared to 0. Any single agreeing cycle restarts the count (glitch rejection).
  - `btn_s2 != stable` and `cnt < DB_CYCLES-1`: `cnt` increments.
  - `btn_s2 != stable` and `cnt == DB_CYCLES-1`: `stable` flips and `cnt` clears. On the same edge, the matching pulse register is set: `o_btn_press` if the new level is the pressed level, else `o_btn_release`.
- Pulse registers are cleared on every edge on which no flip occurs. Pulse width is therefore exactly 1 cycle, and two pulses for the same bit are at least `DB_CYCLES` cycles apart.
- `o_io_btn = stable`, fully registered with no combinational path from raw inputs.
- The four buttons are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- `cnt` never exceeds `DB_CYCLES-1`; no wrap-around is possible.
- **Reset:**
  - `btn_s1`, `btn_s2` and `stable` load the released level: all 1s if `BTN_ACTIVE_LOW=1`, else all 0s.
  - `sw_s1`, `sw_s2` and `o_io_sw` load 0.
  - `cnt`, `o_btn_press` and `o_btn_release` load 0.
  - Reset asserted mid-debounce discards the partial count. No pulse is generated on reset entry or exit.
  - Reset has priority over all other updates.

## Timing
- **Switch latency:** a raw change sampled at edge 1 appears on `o_io_sw` after edge 2.
- **Button latency:** a raw change held steady, first sampled at edge 1, flips `o_io_btn` and raises the pulse at edge `DB_CYCLES+2`. The pulse drops at edge `DB_CYCLES+3`.
- **Minimum accepted raw pulse width:** `DB_CYCLES` cycles after synchronisation. Shorter bounces produce no output change.
- The core samples `o_io_btn` / `o_io_sw` combinationally on its LSU read path. No handshake exists; the outputs are level signals.

## Structure
- **Package `io_pkg`:** holds `NUM_BTN = 4` and `SW_W = 32`, plus the `btn_level_e` encoding (`BTN_RELEASED`, `BTN_PRESSED`) resolved via `BTN_ACTIVE_LOW`.
- **Sub-module `debounce_bit`:** one synchroniser, counter and FSM with its two pulse outputs. Instantiated `NUM_BTN` times with `DB_CYCLES` passed down. The switch synchroniser stays inline in the top.

## Test plan
All scenarios use `DB_CYCLES=4`, `BTN_ACTIVE_LOW=1`.
- **Reset values:** hold `i_rst` high for 3 cycles with `i_btn_raw=4'b0000` (all pressed) and `i_sw_raw=32'hFFFF_FFFF`. Required: `o_io_btn=4'hF`, `o_io_sw=0` and all pulses 0 during reset. After release, `o_io_sw=32'hFFFF_FFFF` after 2 edges; `o_io_btn=4'h0` with `o_btn_press=4'hF` for 1 cycle at edge 6.
- **Clean press:** `i_btn_raw[2]` 1→0 and held. Required: `o_io_btn[2]` falls at edge 6, `o_btn_press=4'b0100` for exactly 1 cycle, no other pulses.
- **Bounce rejection:** `i_btn_raw[0]` toggles 0,1,0,1 every 2 cycles, then holds 0. Required: no change and no pulse during toggling; press pulse 6 edges after the final hold begins.
- **Release and simultaneity:** buttons 1 and 3 pressed and stable, then released on the same edge. Required: `o_btn_release=4'b1010` for 1 cycle at edge 6; `o_io_btn[3:1]` returns to 3'b111.
- **Reset mid-debounce:** press `i_btn_raw[1]`, assert `i_rst` at edge 4 for 1 cycle with the raw input still held. Required: no pulse before reset; `o_io_btn[1]=1` during reset; press pulse exactly 6 edges after reset deasserts.
